// File: rtl/pc_fetch_gen_pkg.sv
// Shared types and constants for the fetch PC generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        PEND = 2'b10
    } pc_state_e;

    localparam int unsigned ILEN_BYTES = 4;

    function automatic logic is_redirect(input logic ex_valid, input pc_src_e src);
        return ex_valid && (src != PC_SEQ);
    endfunction

endpackage

// File: rtl/pc_fetch_gen_target_calc.sv
// Combinational redirect-target and misalignment evaluation.
// PC_ALIGN_CHECK_EN selects trapping of misaligned targets instead of forcing alignment.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h100)
) (
    input  pc_src_e           pc_src_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   alu_result_i,
    output logic [XLEN-1:0]   target_o,
    output logic [XLEN-1:0]   raw_target_o,
    output logic              misalign_o
);

    always_comb begin
        if (pc_src_i == PC_JALR) begin
            raw_target_o = alu_result_i & ~XLEN'(1);
        end else begin
            raw_target_o = ex_pc_i + imm_i;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        misalign_o = raw_target_o[1];
        target_o   = misalign_o ? TRAP_VEC : raw_target_o;
    end
`else
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;

    always_comb begin
        misalign_o = 1'b0;
        target_o   = {raw_target_o[XLEN-1:2], 2'b00};
    end
`endif

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: owns the fetch PC, handshakes with imem, parks redirects behind stalled requests.
// Optional macro PC_ALIGN_CHECK_EN enables misaligned-target trapping to TRAP_VEC.
module pc_fetch_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              ex_valid_i,
    input  logic [1:0]        pc_src_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   alu_result_i,
    output logic [XLEN-1:0]   ex_pc_plus4_o,
    output logic              if_req_valid_o,
    output logic [XLEN-1:0]   if_pc_o,
    input  logic              if_req_ready_i,
    output logic              if_kill_o,
    output logic              flush_o,
    output logic              misalign_o,
    output logic [XLEN-1:0]   bad_addr_o
);

    pc_state_e         state_q, state_n;
    logic [XLEN-1:0]   pc_q, pc_n;
    logic [XLEN-1:0]   pend_q, pend_n;
    logic              held_q, held_n;
    logic              mis_q, mis_n;
    logic [XLEN-1:0]   bad_q, bad_n;

    pc_src_e           pc_src;
    logic              redirect;
    logic [XLEN-1:0]   tgt;
    logic [XLEN-1:0]   tgt_raw;
    logic              tgt_mis;
    logic              req_valid;
    logic              kill;

    assign pc_src   = pc_src_e'(pc_src_i);
    assign redirect = is_redirect(ex_valid_i, pc_src);

    pc_target_calc #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_target_calc (
        .pc_src_i     (pc_src),
        .ex_pc_i      (ex_pc_i),
        .imm_i        (imm_i),
        .alu_result_i (alu_result_i),
        .target_o     (tgt),
        .raw_target_o (tgt_raw),
        .misalign_o   (tgt_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            held_q  <= 1'b0;
            mis_q   <= 1'b0;
            bad_q   <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            pend_q  <= pend_n;
            held_q  <= held_n;
            mis_q   <= mis_n;
            bad_q   <= bad_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        pend_n    = pend_q;
        held_n    = 1'b0;
        mis_n     = 1'b0;
        bad_n     = bad_q;
        req_valid = 1'b0;
        kill      = 1'b0;

        if (redirect) begin
            mis_n = tgt_mis;
            if (tgt_mis) begin
                bad_n = tgt_raw;
            end
        end

        unique case (state_q)
            BOOT: begin
                state_n = RUN;
                if (redirect) begin
                    pc_n = tgt;
                end
            end
            RUN: begin
                // held_q keeps an already-raised request alive through a stall
                req_valid = held_q || !stall_i;
                held_n    = req_valid && !if_req_ready_i;
                if (redirect) begin
                    if (req_valid && !if_req_ready_i) begin
                        pend_n  = tgt;
                        state_n = PEND;
                    end else begin
                        pc_n = tgt;
                    end
                end else if (req_valid && if_req_ready_i) begin
                    pc_n = pc_q + XLEN'(ILEN_BYTES);
                end
            end
            PEND: begin
                req_valid = 1'b1;
                if (redirect) begin
                    pend_n = tgt;
                end
                // a redirect landing on the accept cycle bypasses the parked target
                if (if_req_ready_i) begin
                    kill    = 1'b1;
                    pc_n    = redirect ? tgt : pend_q;
                    state_n = RUN;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    assign ex_pc_plus4_o  = ex_pc_i + XLEN'(ILEN_BYTES);
    assign if_req_valid_o = req_valid;
    assign if_pc_o        = pc_q;
    assign if_kill_o      = kill;
    assign flush_o        = redirect;
    assign misalign_o     = mis_q;
    assign bad_addr_o     = bad_q;

endmodule
